// File: rtl/line_memory_responder.sv
// line_memory_responder
// Memory-side backing store for the data-cache line port. It takes one
// 256-bit line read or write at a time, models a fixed access latency and
// returns a single-cycle acknowledge.
//
// Handshake: a request is taken when enable_i is high in IDLE at a rising
// edge. All request fields are latched at that edge. The transaction then
// runs to completion regardless of the inputs. ack_o pulses high for exactly
// one cycle, and read data on data_o is valid in that same cycle. data_o
// holds its value until the next read completes.
module line_memory_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic [1:0]   dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic [IDX_W-1:0] r_idx;
  logic [255:0]     r_wdata;
  logic             r_ack;
  logic [255:0]     r_rdata;
  logic [255:0]     r_mem [DEPTH];

  logic             w_access;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused_addr;

  // Only the line index bits select a line. Byte offset and upper bits are
  // ignored, so addresses wrap modulo DEPTH lines.
  assign w_idx         = addr_i[5 +: IDX_W];
  assign w_unused_addr = ^addr_i;

  // The access happens on the last WAIT edge. Reset forces IDLE, so a write
  // that is pending when reset arrives never reaches the array.
  assign w_access = (r_state == S_WAIT) && (r_cnt == CNT_LAST);

  assign ack_o       = r_ack;
  assign data_o      = r_rdata;
  assign dbg_state_o = r_state;

  // Request FSM: latch on sample, count the latency, access, acknowledge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (enable_i) begin
            r_write <= write_i;
            r_idx   <= w_idx;
            r_wdata <= data_i;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_access) begin
            if (!r_write) begin
              r_rdata <= r_mem[r_idx];
            end
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage is not reset; it is written only on write completion.
  always_ff @(posedge clk_i) begin
    if (w_access && r_write) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule

// File: doc/line_memory_responder.md
# line_memory_responder

Memory-side responder for the data-cache line interface: it accepts one 256-bit line read or write request at a time from the cache's memory port, models a fixed access latency, and returns a one-cycle acknowledge. It sits outside the CPU top, connected to the CPU's memory-interface pins. It serves as the backing store for cache fills and write-backs in simulation and on FPGA.

## Interface

Parameters:
- DEPTH, 512: number of 256-bit lines; power of two, at least 2.
- LATENCY, 10: cycles from request sample to acknowledge; at least 2.

Ports:
- clk_i, in, 1: clock; all state changes on the rising edge.
- rst_i, in, 1: reset; asynchronous, active-low.
- enable_i, in, 1: request valid; driven by the cache's memory enable output.
- write_i, in, 1: 1 = line write, 0 = line read.
- addr_i, in, 32: byte address; the line index is addr_i[5+log2(DEPTH)-1:5].
- data_i, in, 256: write line data.
- ack_o, out, 1: one-cycle completion pulse.
- data_o, out, 256: read line data.

## Operation

- The storage array holds DEPTH × 256 bits and is not reset.
- The FSM has three states: IDLE, WAIT and ACK.
  - IDLE: when enable_i=1 is sampled, latch write_i, the line index and data_i, clear the counter, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: the counter increments each cycle. When the counter reaches LATENCY-2, perform the access at that edge and go to ACK.
    - Write: array[idx] ← latched data.
    - Read: data_o ← array[idx].
  - ACK: ack_o=1 for exactly this one cycle, then go to IDLE unconditionally.
- Request fields are used only from the latched copy. Changes to addr_i, data_i or write_i after the sampling edge are ignored.
- Deasserting enable_i during WAIT does not abort the transaction. It completes and acknowledges normally.
- If enable_i is still high in the first IDLE cycle after ACK, that is a new request. It is sampled and serviced in full.
- Address bits [4:0] and the bits above the index are ignored. Addresses wrap modulo DEPTH lines.
- data_o changes only on read completion. It holds its value through writes and idle periods.
- A write followed by a read of the same line returns the written data. No bypass is needed because requests are serialized.
- The counter width is clog2(LATENCY). The counter saturates only by leaving WAIT, never by wrapping.

## Timing

- Reset values: ack_o=0, data_o=0, state=IDLE, counter=0.
- If enable_i is sampled at edge E, then:
  - the access takes effect at edge E+LATENCY-1;
  - ack_o is high in the cycle between edges E+LATENCY-1 and E+LATENCY;
  - read data is valid on data_o in the same cycle as ack_o, and held afterwards.
- Minimum spacing between two sampled requests is LATENCY+1 edges: service plus the return to IDLE.
- Throughput is one line per LATENCY+1 cycles.
- Reset asserted mid-transaction:
  - immediately forces IDLE, ack_o=0 and data_o=0;
  - a pending write is dropped and the array is left unmodified;
  - after reset release, nothing is acknowledged until a new request is sampled.
- enable_i sampled in WAIT or ACK has no effect.

## Test plan

- Write then read, with LATENCY=10: write addr 0x0000_0040 with data {8{32'hDEADBEEF}}. ack_o pulses exactly 10 cycles after the sample edge, for 1 cycle. A subsequent read of 0x0000_0040 returns {8{32'hDEADBEEF}} with its ack, and data_o is still that value 5 cycles later.
- Offset and wrap, with DEPTH=512: write addr 0x0000_005F with pattern A, then read 0x0000_4040. The read returns A, because bits [4:0] are ignored and line 2 wraps.
- Input corruption: during WAIT, change addr_i, data_i and write_i, and drop enable_i at cycle 3. The original latched write completes with a single ack, and the original line holds the original data.
- Back-to-back requests: hold enable_i high continuously for a write then a read. Acks arrive at sample+10 and sample+21, and the read returns the just-written data.
- Reset during write: assert rst_i low at cycle 5 of a write to line 7, which previously held 0. ack_o never pulses, data_o=0, and a later read of line 7 returns 0.
- Idle stability: enable_i=0 for 50 cycles after a read. ack_o stays 0 and data_o stays unchanged.
